// File: rtl/secret_number_gen.sv
// Secret number generator: samples a free-running LFSR on a start request, rejects
// out-of-range candidates with bounded retries and a fallback, and holds the result.
module secret_number_gen #(
  parameter int unsigned       WIDTH     = 7,
  parameter int unsigned       MIN_VALUE = 1,
  parameter int unsigned       MAX_VALUE = 99,
  parameter logic [WIDTH-1:0]  SEED      = 7'h5A,
  parameter int unsigned       MAX_TRIES = 16,
  parameter int unsigned       FALLBACK  = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_random_gen,
  input  logic             game_over,
  output logic [WIDTH-1:0] actual_number,
  output logic             number_valid,
  output logic             gen_busy
);

  localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     lfsr_q, lfsr_d;
  logic [WIDTH-1:0]     number_q, number_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic [TRIES_W-1:0]   tries_q, tries_d;
  logic                 start_q, go_q;

  logic start_rise_c, go_rise_c, in_range_c, last_try_c;

  assign start_rise_c = start_random_gen & ~start_q;
  assign go_rise_c    = game_over & ~go_q;
  assign in_range_c   = (lfsr_q >= WIDTH'(MIN_VALUE)) && (lfsr_q <= WIDTH'(MAX_VALUE));
  assign last_try_c   = (tries_q == TRIES_W'(MAX_TRIES - 1));

  // x^7+x^6+1, maximal length, never reaches zero from a nonzero seed
  assign lfsr_d = {lfsr_q[WIDTH-2:0], lfsr_q[WIDTH-1] ^ lfsr_q[WIDTH-2]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      number_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      tries_q  <= '0;
      start_q  <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      number_q <= number_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      tries_q  <= tries_d;
      start_q  <= start_random_gen;
      go_q     <= game_over;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_rise_c) state_d = SAMPLE;
      SAMPLE:  if (in_range_c || last_try_c) state_d = HOLD;
      HOLD: begin
        if (start_rise_c)   state_d = SAMPLE;
        else if (go_rise_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and retry counter; restart in HOLD outranks game_over
  always_comb begin
    number_d = number_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    tries_d  = tries_q;
    case (state_q)
      IDLE: begin
        if (start_rise_c) begin
          busy_d  = 1'b1;
          tries_d = '0;
        end
      end
      SAMPLE: begin
        if (in_range_c) begin
          number_d = lfsr_q;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
        end else if (last_try_c) begin
          number_d = WIDTH'(FALLBACK);
          valid_d  = 1'b1;
          busy_d   = 1'b0;
        end else begin
          tries_d = tries_q + TRIES_W'(1);
        end
      end
      HOLD: begin
        if (start_rise_c) begin
          valid_d = 1'b0;
          busy_d  = 1'b1;
          tries_d = '0;
        end else if (go_rise_c) begin
          valid_d = 1'b0;
        end
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign actual_number = number_q;
  assign number_valid  = valid_q;
  assign gen_busy      = busy_q;

endmodule

// File: tb/tb_secret_number_gen.sv
// Directed bench for secret_number_gen: default instance plus a small-range instance
// that exhausts its retries and falls back.
module tb_secret_number_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_random_gen;
  logic       game_over;
  logic [6:0] actual_number, actual_number4;
  logic       number_valid, number_valid4;
  logic       gen_busy, gen_busy4;

  int tests = 0;
  int fails = 0;
  int busy_count;

  always #5 clk = ~clk;

  secret_number_gen dut (
    .clk              (clk),
    .reset            (reset),
    .start_random_gen (start_random_gen),
    .game_over        (game_over),
    .actual_number    (actual_number),
    .number_valid     (number_valid),
    .gen_busy         (gen_busy)
  );

  secret_number_gen #(.MAX_VALUE(2), .MAX_TRIES(4), .FALLBACK(2)) dut4 (
    .clk              (clk),
    .reset            (reset),
    .start_random_gen (start_random_gen),
    .game_over        (game_over),
    .actual_number    (actual_number4),
    .number_valid     (number_valid4),
    .gen_busy         (gen_busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then park on the falling edge for sampling/driving
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start_random_gen = 1'b0;
    game_over = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    start_random_gen = 1'b0;
    game_over = 1'b0;

    // Reset state and free-running LFSR sequence
    do_reset();
    check("rst_number", 32'(actual_number), 32'd0);
    check("rst_valid", 32'(number_valid), 32'd0);
    check("rst_busy", 32'(gen_busy), 32'd0);
    step(); check("lfsr_e1", 32'(dut.lfsr_q), 32'd53);
    step(); check("lfsr_e2", 32'(dut.lfsr_q), 32'd107);
    step(); check("lfsr_e3", 32'(dut.lfsr_q), 32'd86);
    step(); check("lfsr_e4", 32'(dut.lfsr_q), 32'd45);

    // Start at edge 1: default accepts 53; small-range instance falls back to 2
    do_reset();
    start_random_gen = 1'b1;
    step();
    check("t2_busy_e1", 32'(gen_busy), 32'd1);
    check("t2_valid_e1", 32'(number_valid), 32'd0);
    step();
    check("t2_number", 32'(actual_number), 32'd53);
    check("t2_valid", 32'(number_valid), 32'd1);
    check("t2_busy", 32'(gen_busy), 32'd0);
    step();
    step();
    check("t4_valid_e4", 32'(number_valid4), 32'd0);
    check("t4_busy_e4", 32'(gen_busy4), 32'd1);
    step();
    check("t4_number", 32'(actual_number4), 32'd2);
    check("t4_valid", 32'(number_valid4), 32'd1);
    check("t4_busy", 32'(gen_busy4), 32'd0);

    // Start at edge 2: 107 rejected, 86 accepted, busy exactly 2 cycles
    do_reset();
    step();
    start_random_gen = 1'b1;
    step(); check("t3_busy_e2", 32'(gen_busy), 32'd1);
    step(); check("t3_busy_e3", 32'(gen_busy), 32'd1);
    check("t3_valid_e3", 32'(number_valid), 32'd0);
    step();
    check("t3_busy_e4", 32'(gen_busy), 32'd0);
    check("t3_valid_e4", 32'(number_valid), 32'd1);
    check("t3_number", 32'(actual_number), 32'd86);

    // game_over in HOLD drops valid, keeps the number, returns to IDLE
    start_random_gen = 1'b0;
    game_over = 1'b1;
    step();
    check("t5_go_valid", 32'(number_valid), 32'd0);
    check("t5_go_number", 32'(actual_number), 32'd86);
    check("t5_go_busy", 32'(gen_busy), 32'd0);
    game_over = 1'b0;
    step();
    check("t5_idle_valid", 32'(number_valid), 32'd0);
    start_random_gen = 1'b1;
    step();
    step();
    step();
    check("t5_regen_number", 32'(actual_number), 32'd94);
    check("t5_regen_valid", 32'(number_valid), 32'd1);

    // Simultaneous start and game_over in HOLD: restart wins
    start_random_gen = 1'b0;
    step();
    start_random_gen = 1'b1;
    game_over = 1'b1;
    step();
    check("t5_both_valid", 32'(number_valid), 32'd0);
    check("t5_both_busy", 32'(gen_busy), 32'd1);
    step();
    step();
    step();
    check("t5_both_number", 32'(actual_number), 32'd88);
    check("t5_both_valid2", 32'(number_valid), 32'd1);

    // Level-held start gives exactly one regeneration
    start_random_gen = 1'b0;
    game_over = 1'b0;
    step();
    start_random_gen = 1'b1;
    busy_count = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (gen_busy) busy_count++;
    end
    check("t6_busy_count", 32'(busy_count), 32'd1);
    check("t6_number", 32'(actual_number), 32'd70);
    check("t6_valid", 32'(number_valid), 32'd1);

    // Asynchronous reset mid-SAMPLE
    start_random_gen = 1'b0;
    step();
    start_random_gen = 1'b1;
    step();
    check("t6_sample_busy", 32'(gen_busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t6_arst_busy", 32'(gen_busy), 32'd0);
    check("t6_arst_valid", 32'(number_valid), 32'd0);
    check("t6_arst_number", 32'(actual_number), 32'd0);
    check("t6_arst_lfsr", 32'(dut.lfsr_q), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
